instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the instruction decoder.
//  Owns the fetch PC and issues single-outstanding word requests to instruction memory.
//  Buffers returned words with their PCs in a small FIFO and presents the head to the decoder as inst/inst_pc/inst_valid.
//  Flushes and re-steers on a redirect (jump, taken branch, trap).
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC after reset; [1:0] must be 0
//  DEPTH     2              FIFO entries; power of two, >=2
//  NOP_INST  32'h0000_0013  word driven on inst when the FIFO is empty (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rstn         in   1   asynchronous active-low reset
//  mem_req      out  1   fetch request; held until mem_ack
//  mem_addr     out  32  word-aligned fetch address; stable while mem_req=1
//  mem_ack      in   1   request complete; mem_rdata valid in the same cycle
//  mem_rdata    in   32  fetched instruction word
//  redirect     in   1   one-cycle pulse: flush and refetch from redirect_pc
//  redirect_pc  in   32  new PC; bits [1:0] ignored (treated as 0)
//  stall        in   1   downstream not accepting this cycle
//  inst         out  32  FIFO head word to decoder, or NOP_INST when empty
//  inst_pc      out  32  PC of the FIFO head, or 32'h0 when empty
//  inst_valid   out  1   FIFO non-empty
// BEHAVIOUR
//  - Reset (async): FIFO empty (count=0); fetch_pc=RESET_PC; state IDLE; mem_req=0; mem_addr=RESET_PC; inst=NOP_INST; inst_pc=0; inst_valid=0.
//  - Outputs inst, inst_pc and inst_valid are driven from FIFO storage and count only; no combinational path from mem_rdata.
//  - Pop: occurs when inst_valid & ~stall; the head advances at the next edge.
//  - FSM states:
//    - IDLE: if (count + pops_pending_none) < DEPTH, i.e. a free slot exists after this cycle's pop, assert mem_req with mem_addr=fetch_pc in the same cycle and move to REQ. Otherwise stay IDLE.
//    - REQ: keep mem_req=1 and mem_addr unchanged.
//      - On mem_ack: push {fetch_pc, mem_rdata}; fetch_pc += 4 (wraps modulo 2^32); go to IDLE.
//      - Back-to-back: a new request may be issued in the cycle after an ack, never in the ack cycle itself.
//    - DRAIN: entered when a redirect arrives while in REQ without mem_ack. mem_req stays 1 with the old address, since a request is never retracted. On mem_ack, discard mem_rdata and go to IDLE.
//  - Slot reservation: a request is issued only when a FIFO slot is guaranteed, so a push never overflows.
//  - Simultaneous push and pop: count is unchanged and both take effect.
//  - Pointers wrap modulo DEPTH.
//  - Redirect has priority over push, pop and ack. In its cycle:
//    - count:=0;
//    - fetch_pc:={redirect_pc[31:2],2'b00};
//    - any ack data arriving in that cycle is discarded.
//    - Next state: DRAIN if REQ and no ack, otherwise IDLE.
//    - inst_valid is 0 on the following cycle.
//  - Redirect while in DRAIN: update fetch_pc again and remain in DRAIN.
//  - Redirect while stall=1: flush regardless of stall.
//  - Latency: redirect to first inst_valid is >=3 cycles (IDLE request, ack, visible); 2 + memory wait cycles when mem_ack is not immediate.
// CONFIGURATION
//  IFETCH_ERR_EN defined:
//    - Adds port mem_err (in, 1; qualified by mem_ack) and port inst_err (out, 1; reset 0).
//    - A faulting fetch is pushed with err=1; inst_err mirrors the head entry's flag.
//    - After a faulting push, no further requests are issued until redirect.
//  IFETCH_ERR_EN undefined: neither port exists; every ack is treated as a good fetch.
// TESTING
//  - Reset, mem_ack tied high one cycle after each req, stall=0:
//    - mem_addr 0x0,0x4,0x8...;
//    - inst_valid first high 2 cycles after rstn deassert;
//    - inst_pc steps by 4.
//  - stall=1 held for 10 cycles:
//    - FIFO fills to DEPTH and mem_req stays 0;
//    - inst/inst_pc hold at the same entry;
//    - on release, entries pop in order with no loss or duplicate.
//  - Empty FIFO: inst=32'h0000_0013, inst_pc=0, inst_valid=0.
//  - Redirect to 0x0000_0102 with no outstanding request:
//    - next mem_addr=0x0000_0100;
//    - stale FIFO entries never appear on inst.
//  - Redirect to 0x200 while req to 0x10 is waiting, ack 3 cycles later with 0xDEADBEEF:
//    - mem_addr stays 0x10 until ack;
//    - 0xDEADBEEF is dropped;
//    - the next req is to 0x200.
//  - IFETCH_ERR_EN, ack with mem_err=1 at 0x8:
//    - entry 0x8 shows inst_err=1 and mem_req stays 0;
//    - redirect to 0x40 resumes fetching at 0x40.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request channel, redirect/stall
// control from the back end, and the decoder-facing head-of-queue view.
// Optional macro IFETCH_ERR_EN adds mem_err / inst_err.
interface instr_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef IFETCH_ERR_EN
  logic        mem_err;
  logic        inst_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err,
    input  redirect, redirect_pc, stall,
    output inst, inst_pc, inst_valid, inst_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err,
    output redirect, redirect_pc, stall,
    input  inst, inst_pc, inst_valid, inst_err
  );
`else
  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect, redirect_pc, stall,
    output inst, inst_pc, inst_valid
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect, redirect_pc, stall,
    input  inst, inst_pc, inst_valid
  );
`endif
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one outstanding word
// request at a time, buffers returned words with their PCs and presents the
// head to the decoder. Redirect flushes the queue and re-steers fetch.
// Optional macro IFETCH_ERR_EN: tags faulting fetches and halts fetching
// after one until the next redirect.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rstn,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

`ifdef IFETCH_ERR_EN
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;
`else
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             fifo_q [DEPTH];

  logic               valid_c;
  logic               pop_c;
  logic               push_c;
  logic               mem_req_c;
  logic               issue_ok_c;
  logic               fetch_block_c;
  entry_t             push_entry_c;
  entry_t             head_c;

`ifdef IFETCH_ERR_EN
  logic               halt_q, halt_d;
  assign fetch_block_c = halt_q;
`else
  assign fetch_block_c = 1'b0;
`endif

  assign valid_c = (count_q != '0);
  assign pop_c   = valid_c & ~bus.stall;
  assign head_c  = fifo_q[rd_ptr_q];

  // A request may start only out of reset, with no redirect this cycle, and
  // with a slot guaranteed once this cycle's pop (if any) has happened.
  assign issue_ok_c = rstn & ~bus.redirect & ~fetch_block_c &
                      ((count_q < DEPTH_CNT) | pop_c);

  // Entry written on a good acknowledge.
  always_comb begin
    push_entry_c      = '0;
    push_entry_c.pc   = req_addr_q;
    push_entry_c.word = bus.mem_rdata;
`ifdef IFETCH_ERR_EN
    push_entry_c.err  = bus.mem_err;
`endif
  end

  // Fetch FSM next-state, request handshake and push decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    mem_req_c  = 1'b0;
    push_c     = 1'b0;
`ifdef IFETCH_ERR_EN
    halt_d     = halt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (issue_ok_c) begin
          mem_req_c  = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_c = 1'b1;
        if (bus.redirect) begin
          state_d = bus.mem_ack ? S_IDLE : S_DRAIN;
        end else if (bus.mem_ack) begin
          push_c     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_IDLE;
`ifdef IFETCH_ERR_EN
          if (bus.mem_err) halt_d = 1'b1;
`endif
        end
      end
      S_DRAIN: begin
        // The stale request cannot be retracted; swallow its response.
        mem_req_c = 1'b1;
        if (bus.mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
`ifdef IFETCH_ERR_EN
      halt_d     = 1'b0;
`endif
    end
  end

  // Queue pointer and occupancy update; redirect empties the queue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IFETCH_ERR_EN
      halt_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef IFETCH_ERR_EN
      halt_q     <= halt_d;
`endif
    end
  end

  // Queue storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= push_entry_c;
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_addr   = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;
  assign bus.inst_valid = valid_c;
  assign bus.inst       = valid_c ? head_c.word : NOP_INST;
  assign bus.inst_pc    = valid_c ? head_c.pc   : 32'h0;
`ifdef IFETCH_ERR_EN
  assign bus.inst_err   = valid_c & head_c.err;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus a randomized phase,
// every cycle compared against a queue-based reference of the fetch rules.
module tb_instr_fetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rstn;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH),
    .NOP_INST (NOP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        err;
  } ment_t;

  int checks;
  int passes;
  int fails;

  // reference state
  ment_t       mq[$];
  logic [31:0] m_fpc;
  bit          m_out;
  logic [31:0] m_out_addr;
  bit          m_drop;
  bit          m_halt;

  // memory responder state
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_seen;
  int          lat_lo;
  int          lat_hi;
  bit          use_fixed;
  logic [31:0] fixed_data;
  bit          err_en;
  logic [31:0] err_addr;

  // last sampled DUT outputs
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic        s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample and compare
  // 1ns later, advance the reference and the memory responder.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic        ack;
    logic [31:0] rdata;
    logic        merr;
    bit          pop;
    bit          e_req;
    logic [31:0] e_addr;
    int          occ;

    ack   = mem_busy && (mem_cnt == 1);
    rdata = use_fixed ? fixed_data : $urandom();
    merr  = err_en && ack && (mem_addr_seen == err_addr);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.mem_ack     = ack;
    bus.mem_rdata   = rdata;
`ifdef IFETCH_ERR_EN
    bus.mem_err     = merr;
`endif
    #1;
    s_req   = bus.mem_req;
    s_addr  = bus.mem_addr;
    s_valid = bus.inst_valid;
    s_inst  = bus.inst;
    s_pc    = bus.inst_pc;
`ifdef IFETCH_ERR_EN
    s_err   = bus.inst_err;
`else
    s_err   = 1'b0;
`endif

    pop    = (mq.size() > 0) && !st;
    occ    = mq.size() - (pop ? 1 : 0);
    e_req  = m_out || (!rd && !m_halt && (occ < DEPTH));
    e_addr = m_out ? m_out_addr : m_fpc;

    chk("mem_req", 32'(s_req), 32'(e_req));
    if (e_req) chk("mem_addr", s_addr, e_addr);
    chk("inst_valid", 32'(s_valid), 32'(mq.size() > 0));
    chk("inst", s_inst, (mq.size() > 0) ? mq[0].word : NOP);
    chk("inst_pc", s_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
`ifdef IFETCH_ERR_EN
    chk("inst_err", 32'(s_err), (mq.size() > 0) ? 32'(mq[0].err) : 32'h0);
`endif

    if (pop) void'(mq.pop_front());
    if (rd) begin
      mq.delete();
      m_fpc  = rpc & ~32'h3;
      m_halt = 1'b0;
      if (m_out && !ack) m_drop = 1'b1;
      else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
    end else if (m_out && ack) begin
      if (!m_drop) begin
        mq.push_back('{pc: m_out_addr, word: rdata, err: merr});
        m_fpc = m_fpc + 32'd4;
        if (merr) m_halt = 1'b1;
      end
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (!m_out && e_req) begin
      m_out      = 1'b1;
      m_out_addr = m_fpc;
    end

    if (ack) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    else if (s_req === 1'b1) begin
      mem_busy      = 1'b1;
      mem_cnt       = $urandom_range(lat_hi, lat_lo);
      mem_addr_seen = s_addr;
    end

    @(negedge clk);
  endtask

  initial begin
    bit seen;
    checks = 0; passes = 0; fails = 0;
    m_fpc = 32'h0; m_out = 1'b0; m_out_addr = 32'h0; m_drop = 1'b0; m_halt = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr_seen = 32'h0;
    lat_lo = 1; lat_hi = 1; use_fixed = 1'b0; fixed_data = 32'h0;
    err_en = 1'b0; err_addr = 32'h0;

    rstn            = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'h0;
`ifdef IFETCH_ERR_EN
    bus.mem_err     = 1'b0;
`endif

    // reset values
    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_inst", bus.inst, NOP);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
`ifdef IFETCH_ERR_EN
    chk("rst_inst_err", 32'(bus.inst_err), 32'h0);
`endif

    // sequential fetch with one-cycle memory
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 32'h0);
    chk("first_addr", s_addr, 32'h0);
    step(0, 0, 32'h0);
    chk("not_yet_valid", 32'(s_valid), 32'h0);
    step(0, 0, 32'h0);
    chk("first_valid", 32'(s_valid), 32'h1);
    chk("first_pc", s_pc, 32'h0);
    repeat (10) step(0, 0, 32'h0);

    // hold stall: queue fills, requests stop, head holds
    repeat (10) step(1, 0, 32'h0);
    chk("stall_no_req", 32'(s_req), 32'h0);
    chk("stall_valid", 32'(s_valid), 32'h1);
    repeat (8) step(0, 0, 32'h0);

    // redirect to 0x102 with queue full and no request in flight
    repeat (10) step(1, 0, 32'h0);
    step(1, 1, 32'h0000_0102);
    step(1, 0, 32'h0);
    chk("redir_addr", s_addr, 32'h0000_0100);
    chk("redir_req", 32'(s_req), 32'h1);
    chk("empty_inst", s_inst, NOP);
    chk("empty_pc", s_pc, 32'h0);
    chk("empty_valid", 32'(s_valid), 32'h0);
    repeat (8) step(0, 0, 32'h0);

    // redirect to 0x200 while a request to 0x10 waits three cycles
    repeat (10) step(1, 0, 32'h0);
    lat_lo = 3; lat_hi = 3;
    use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
    step(1, 1, 32'h0000_0010);
    step(0, 0, 32'h0);
    chk("wait_req_addr", s_addr, 32'h0000_0010);
    step(0, 1, 32'h0000_0200);
    step(0, 0, 32'h0);
    chk("drain_addr", s_addr, 32'h0000_0010);
    chk("drain_req", 32'(s_req), 32'h1);
    step(0, 0, 32'h0);
    step(0, 0, 32'h0);
    chk("after_drain_addr", s_addr, 32'h0000_0200);
    chk("after_drain_req", 32'(s_req), 32'h1);
    use_fixed = 1'b0;
    lat_lo = 1; lat_hi = 1;
    repeat (8) begin
      step(0, 0, 32'h0);
      chk("no_stale_word", 32'(s_valid && s_inst == 32'hDEAD_BEEF), 32'h0);
    end

    // randomized traffic
    lat_lo = 1; lat_hi = 4;
    repeat (600) begin
      step(($urandom_range(99, 0) < 30) ? 1'b1 : 1'b0,
           ($urandom_range(99, 0) < 3)  ? 1'b1 : 1'b0,
           $urandom());
    end

`ifdef IFETCH_ERR_EN
    // faulting fetch at 0x8 halts fetch until redirect
    lat_lo = 1; lat_hi = 1;
    err_en = 1'b1; err_addr = 32'h0000_0008;
    step(0, 1, 32'h0);
    seen = 1'b0;
    repeat (16) begin
      step(0, 0, 32'h0);
      if (s_valid && s_pc == 32'h8 && s_err) seen = 1'b1;
    end
    chk("err_entry_seen", 32'(seen), 32'h1);
    chk("err_halt_req", 32'(s_req), 32'h0);
    err_en = 1'b0;
    step(0, 1, 32'h0000_0040);
    step(0, 0, 32'h0);
    chk("err_resume_req", 32'(s_req), 32'h1);
    chk("err_resume_addr", s_addr, 32'h0000_0040);
    repeat (8) step(0, 0, 32'h0);
`else
    seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
